// File: rtl/traffic_pkg.sv
// Shared light codes, FSM state encoding and a small sizing helper for the phased
// traffic controller.
package traffic_pkg;

  localparam logic [2:0] LightGreen  = 3'b010;
  localparam logic [2:0] LightYellow = 3'b110;
  localparam logic [2:0] LightRed    = 3'b100;

  typedef enum logic [2:0] {
    StGreen,
    StYellow,
    StAllRed,
    StPedOn,
    StPedBlink
  } state_e;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/traffic_timer.sv
// Loadable dwell down-counter with a done flag, plus the quarter-second blink toggle
// used while the walk lamp flashes.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned QUARTER = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             blink_en,
  output logic             done,
  output logic             blink
);

  localparam int unsigned QW = $clog2(QUARTER + 1);
  localparam logic [QW-1:0] QReload = QW'(QUARTER - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [QW-1:0]    qcnt_q;
  logic             blink_q;

  // Loading with dwell-1 makes done rise on the last cycle of the state.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      qcnt_q  <= QReload;
      blink_q <= 1'b0;
    end else if (blink_en) begin
      if (qcnt_q == '0) begin
        qcnt_q  <= QReload;
        blink_q <= ~blink_q;
      end else begin
        qcnt_q <= qcnt_q - 1'b1;
      end
    end
  end

  assign done  = (cnt_q == '0);
  assign blink = blink_q;

endmodule

// File: rtl/traffic_phased.sv
// Round-robin N-phase traffic controller with a pedestrian phase after the last vehicle
// phase. Define TRAFFIC_ALL_RED_EN to insert a 1 s all-red clearance after each yellow.
module traffic_phased
  import traffic_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SEC = 50_000_000,
  parameter int unsigned N_PHASES       = 2,
  parameter int unsigned N_BUTTONS      = 4,
  parameter int unsigned GREEN_SEC      = 3,
  parameter int unsigned YELLOW_SEC     = 2,
  parameter int unsigned PED_ON_SEC     = 2,
  parameter int unsigned PED_BLINK_SEC  = 2
) (
  input  logic                        clk,
  input  logic                        i_maintenance,
  input  logic [N_BUTTONS-1:0]        i_ped_buttons,
  output logic [3*N_PHASES-1:0]       o_lights,
  output logic                        o_light_ped,
  output logic [$clog2(N_PHASES)-1:0] o_phase,
  output logic                        o_ped_pending
);

  localparam int unsigned PW        = $clog2(N_PHASES);
  localparam int unsigned GreenCyc  = GREEN_SEC * CYCLES_PER_SEC;
  localparam int unsigned YellowCyc = YELLOW_SEC * CYCLES_PER_SEC;
  localparam int unsigned PedOnCyc  = PED_ON_SEC * CYCLES_PER_SEC;
  localparam int unsigned PedBlkCyc = PED_BLINK_SEC * CYCLES_PER_SEC;
  localparam int unsigned MaxCyc    = max_u(max_u(GreenCyc, YellowCyc),
                                            max_u(max_u(PedOnCyc, PedBlkCyc), CYCLES_PER_SEC));
  localparam int unsigned CNT_W     = $clog2(MaxCyc + 1);
  localparam logic [PW-1:0] LastPhase = PW'(N_PHASES - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             pending_q, pending_d;
  state_e           exit_state;
  logic [PW-1:0]    exit_phase;
  logic             done, blink, load;
  logic [CNT_W-1:0] load_val;
  logic             press;

  assign press = |i_ped_buttons;

  // Exit rule shared by YELLOW (no clearance) and ALL_RED: pending request diverts only
  // after the last phase, judged on the registered pending bit.
  always_comb begin
    exit_state = StGreen;
    exit_phase = (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
    if (phase_q == LastPhase && pending_q) begin
      exit_state = StPedOn;
      exit_phase = phase_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    pending_d = pending_q;
    if (press && state_q != StPedOn && state_q != StPedBlink) begin
      pending_d = 1'b1;
    end
    if (done) begin
      case (state_q)
        StGreen: state_d = StYellow;
        StYellow: begin
`ifdef TRAFFIC_ALL_RED_EN
          state_d = StAllRed;
`else
          state_d = exit_state;
          phase_d = exit_phase;
`endif
        end
`ifdef TRAFFIC_ALL_RED_EN
        StAllRed: begin
          state_d = exit_state;
          phase_d = exit_phase;
        end
`endif
        StPedOn: state_d = StPedBlink;
        StPedBlink: begin
          state_d = StGreen;
          phase_d = '0;
        end
        default: begin
          state_d = StGreen;
          phase_d = '0;
        end
      endcase
    end
    if (state_d == StPedOn && state_q != StPedOn) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    load_val = CNT_W'(GreenCyc - 1);
    if (!i_maintenance) begin
      case (state_d)
        StYellow:   load_val = CNT_W'(YellowCyc - 1);
        StAllRed:   load_val = CNT_W'(CYCLES_PER_SEC - 1);
        StPedOn:    load_val = CNT_W'(PedOnCyc - 1);
        StPedBlink: load_val = CNT_W'(PedBlkCyc - 1);
        default:    load_val = CNT_W'(GreenCyc - 1);
      endcase
    end
  end

  // Every state change happens on done, so done doubles as the reload strobe.
  assign load = i_maintenance | done;

  always_ff @(posedge clk) begin
    if (i_maintenance) begin
      state_q   <= StGreen;
      phase_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
    end
  end

  traffic_timer #(
    .CNT_W   (CNT_W),
    .QUARTER (CYCLES_PER_SEC / 4)
  ) u_timer (
    .clk      (clk),
    .rst      (i_maintenance),
    .load     (load),
    .load_val (load_val),
    .blink_en (state_q == StPedBlink),
    .done     (done),
    .blink    (blink)
  );

  always_comb begin
    o_lights = '0;
    for (int p = 0; p < N_PHASES; p++) begin
      o_lights[3*p +: 3] = LightRed;
      if (phase_q == PW'(p)) begin
        if (state_q == StGreen)  o_lights[3*p +: 3] = LightGreen;
        if (state_q == StYellow) o_lights[3*p +: 3] = LightYellow;
      end
    end
  end

  assign o_light_ped   = (state_q == StPedOn) || (state_q == StPedBlink && blink);
  assign o_phase       = phase_q;
  assign o_ped_pending = pending_q;

endmodule
